// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// data port (0) and the loader/debug port (1); every access takes exactly 3 cycles.
module dm_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic [DW-1:0] rdata0,
  output logic          done0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic [DW-1:0] rdata1,
  output logic          done1,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_nxt;
  logic          prio;
  logic          grant_vld;
  logic          grant_sel;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          lat_we;

  // With both ports requesting, the one matching prio wins.
  always_comb begin
    grant_vld = req0 | req1;
    grant_sel = (req0 && req1) ? prio : req1;
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      owner     <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            owner     <= grant_sel;
            prio      <= ~grant_sel;
            lat_addr  <= grant_sel ? addr1  : addr0;
            lat_wdata <= grant_sel ? wdata1 : wdata0;
            lat_we    <= grant_sel ? we1    : we0;
          end
        end
        ACCESS: begin
          // Read data is captured for writes too (pre-write contents).
          if (owner) begin
            rdata1 <= mem_rd;
            done1  <= 1'b1;
          end else begin
            rdata0 <= mem_rd;
            done0  <= 1'b1;
          end
        end
        DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
        end
        default: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
        end
      endcase
    end
  end

  // Write enable is combinational on state so an async reset kills it at once.
  assign mem_we = (state == ACCESS) && lat_we;
  assign mem_a  = lat_addr;
  assign mem_wd = lat_wdata;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: DM model, vector table, scoreboard of completions,
// reset-in-access and round-robin contention sequences.
module tb_dm_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic [DW-1:0] rdata0, rdata1;
  logic          done0, done1;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic          mem_we;
  logic [DW-1:0] mem_rd;
  logic          busy, owner;

  dm_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .done0(done0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .done1(done1),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write on rising edge.
  logic [DW-1:0] dm [2**AW];
  assign mem_rd = dm[mem_a];
  always @(posedge clk) if (mem_we) dm[mem_a] <= mem_wd;

  int errors = 0;
  int checks = 0;

  typedef struct { bit port; logic [DW-1:0] rdata; } exp_t;
  exp_t sb[$];
  logic [DW-1:0] last_rd [2];

  typedef struct {
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every completion pulse pops the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (done0 || done1)) begin
      exp_t e;
      chk("done_onehot", {31'd0, done0 & done1}, 32'd0);
      chk("owner_in_done", {31'd0, owner}, {31'd0, done1});
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: got done%0d expected none at %0t", done1, $time);
      end else begin
        e = sb.pop_front();
        chk("sb_port", {31'd0, done1}, {31'd0, e.port});
        chk("sb_rdata", done1 ? rdata1 : rdata0, e.rdata);
      end
    end
  end

  task automatic access(input vec_t v);
    int n, wecnt;
    sb.push_back('{v.port, v.exp_rd});
    if (!v.port) begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end else begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end
    n = 0;
    wecnt = 0;
    do begin
      @(negedge clk);
      n++;
      if (mem_we) begin
        wecnt++;
        chk("mem_a", {27'd0, mem_a}, {27'd0, v.addr});
        chk("mem_wd", mem_wd, v.wdata);
      end
    end while (!(v.port ? done1 : done0) && n < 10);
    chk("latency", n, 2);
    chk("we_cycles", wecnt, v.we ? 1 : 0);
    chk("other_rdata_hold", v.port ? rdata0 : rdata1, last_rd[!v.port]);
    last_rd[v.port] = v.exp_rd;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    chk("idle_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdata0"}, rdata0, '0);
    chk({tag, "_rdata1"}, rdata1, '0);
    chk({tag, "_ctl"}, {25'd0, done0, done1, mem_we, busy, owner, 2'b00}, 32'd0);
    chk({tag, "_mem_a"}, {27'd0, mem_a}, 32'd0);
    chk({tag, "_mem_wd"}, mem_wd, '0);
  endtask

  initial begin
    int seen, prev_cyc, cyc;
    for (int i = 0; i < 2**AW; i++) dm[i] = '0;
    last_rd[0] = '0;
    last_rd[1] = '0;

    vecs[0] = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 5'd5,  32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 5'd31, 32'h12345678, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 5'd31, 32'h0,        32'h12345678};
    vecs[4] = '{1'b1, 1'b0, 5'd5,  32'h0,        32'hDEADBEEF};
    vecs[5] = '{1'b0, 1'b1, 5'd0,  32'hA5A5A5A5, 32'h0};
    vecs[6] = '{1'b1, 1'b1, 5'd0,  32'h5A5A5A5A, 32'hA5A5A5A5};
    vecs[7] = '{1'b0, 1'b0, 5'd0,  32'h0,        32'h5A5A5A5A};
    vecs[8] = '{1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 32'h12345678};
    vecs[9] = '{1'b1, 1'b0, 5'd31, 32'h0,        32'hFFFFFFFF};

    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) access(vecs[i]);

    // Reset lands during the ACCESS cycle of a write to addr 3.
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd3; wdata0 = 32'hFFFFFFFF;
    @(negedge clk);
    chk("pre_rst_we", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1 chk_reset_outputs("rst_access");
    req0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    chk("rst_no_done", {30'd0, done0, done1}, 32'd0);
    rst_n = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    access('{1'b0, 1'b0, 5'd3, 32'h0, 32'h0});

    // Fresh reset so prio starts at port 0, then hold both requests.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd31;
    for (int i = 0; i < 20; i++)
      sb.push_back('{bit'(i % 2), (i % 2) ? 32'hFFFFFFFF : 32'hDEADBEEF});
    seen = 0;
    prev_cyc = 0;
    cyc = 0;
    while (seen < 20 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done0 || done1) begin
        if (seen == 0) chk("first_done_cycle", cyc, 2);
        else chk("contention_gap", cyc - prev_cyc, 3);
        prev_cyc = cyc;
        seen++;
        if (seen == 20) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    chk("contention_count", seen, 20);
    repeat (3) @(negedge clk);
    chk("final_idle", {31'd0, busy}, 32'd0);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
